// File: rtl/shift_arbiter.sv
// Two-requester front end for a single 32-bit barrel shifter: round-robin or
// fixed-priority grant, registered operands, registered result with valid/ready.

module shift_mux (
    input  logic [31:0] d,
    input  logic [4:0]  sa,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] sh,
    output logic        carry
);

    logic        fill;
    logic [32:0] s0;
    logic [32:0] s1;
    logic [32:0] s2;
    logic [32:0] s3;
    logic [32:0] s4;
    logic [32:0] s5;

    // A guard bit below (right) or above (left) the word collects the last bit shifted out.
    assign fill = right & arith & d[31];
    assign s0   = right ? {d, 1'b0} : {1'b0, d};

    assign s1 = !sa[0] ? s0 : (right ? {fill, s0[32:1]}          : {s0[31:0], 1'b0});
    assign s2 = !sa[1] ? s1 : (right ? {{2{fill}}, s1[32:2]}     : {s1[30:0], 2'b0});
    assign s3 = !sa[2] ? s2 : (right ? {{4{fill}}, s2[32:4]}     : {s2[28:0], 4'b0});
    assign s4 = !sa[3] ? s3 : (right ? {{8{fill}}, s3[32:8]}     : {s3[24:0], 8'b0});
    assign s5 = !sa[4] ? s4 : (right ? {{16{fill}}, s4[32:16]}   : {s4[16:0], 16'b0});

    assign sh    = right ? s5[32:1] : s5[31:0];
    assign carry = right ? s5[0]    : s5[32];

endmodule

module shift_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req0,
    input  logic [31:0] d0,
    input  logic [4:0]  sa0,
    input  logic        right0,
    input  logic        arith0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [31:0] d1,
    input  logic [4:0]  sa1,
    input  logic        right1,
    input  logic        arith1,
    output logic        gnt1,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] sh,
    output logic        carry,
    output logic        busy
);

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  sa;
        logic        right;
        logic        arith;
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t    state;
    state_t    state_n;
    shift_op_t req_op0;
    shift_op_t req_op1;
    shift_op_t op;
    logic      op_id;
    logic      last_id;
    logic      pick1;
    logic [31:0] mux_sh;
    logic        mux_carry;

    assign req_op0 = '{d: d0, sa: sa0, right: right0, arith: arith0};
    assign req_op1 = '{d: d1, sa: sa1, right: right1, arith: arith1};

    // On a tie the fair arbiter favours whoever was not served last.
    assign pick1 = (req0 & req1) ? (FAIR ? ~last_id : 1'b0) : req1;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    gnt0    = ~pick1;
                    gnt1    = pick1;
                    state_n = EXEC;
                end
            end
            EXEC: state_n = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    shift_mux u_shift_mux (
        .d     (op.d),
        .sa    (op.sa),
        .right (op.right),
        .arith (op.arith),
        .sh    (mux_sh),
        .carry (mux_carry)
    );

    // Operand capture, result register and response handshake.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            op         <= '0;
            op_id      <= 1'b0;
            last_id    <= 1'b1;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            sh         <= '0;
            carry      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            if (gnt0 | gnt1) begin
                op      <= gnt1 ? req_op1 : req_op0;
                op_id   <= gnt1;
                last_id <= gnt1;
            end
            if (state == EXEC) begin
                sh         <= mux_sh;
                carry      <= mux_carry;
                resp_id    <= op_id;
                resp_valid <= 1'b1;
            end else if ((state == RESP) && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomised and directed bench for shift_arbiter; a fair and a fixed-priority
// instance share all inputs and are checked against an arithmetic reference.

module tb_shift_arbiter;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  sa;
        logic        right;
        logic        arith;
    } op_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req0, req1, right0, right1, arith0, arith1, resp_ready;
    logic [31:0] d0, d1;
    logic [4:0]  sa0, sa1;

    logic        gnt0, gnt1, resp_valid, resp_id, carry, busy;
    logic [31:0] sh;
    logic        f_gnt0, f_gnt1, f_resp_valid, f_resp_id, f_carry, f_busy;
    logic [31:0] f_sh;

    int errors = 0;
    int checks = 0;
    bit m_last;

    always #5 clk = ~clk;

    shift_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .clrn(clrn),
        .req0(req0), .d0(d0), .sa0(sa0), .right0(right0), .arith0(arith0), .gnt0(gnt0),
        .req1(req1), .d1(d1), .sa1(sa1), .right1(right1), .arith1(arith1), .gnt1(gnt1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .sh(sh), .carry(carry), .busy(busy)
    );

    shift_arbiter #(.FAIR(1'b0)) dut_fp (
        .clk(clk), .clrn(clrn),
        .req0(req0), .d0(d0), .sa0(sa0), .right0(right0), .arith0(arith0), .gnt0(f_gnt0),
        .req1(req1), .d1(d1), .sa1(sa1), .right1(right1), .arith1(arith1), .gnt1(f_gnt1),
        .resp_valid(f_resp_valid), .resp_ready(resp_ready), .resp_id(f_resp_id),
        .sh(f_sh), .carry(f_carry), .busy(f_busy)
    );

    function automatic op_t mk(input logic [31:0] d, input logic [4:0] sa, input bit rt, input bit ar);
        op_t o;
        o.d = d; o.sa = sa; o.right = rt; o.arith = ar;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.d     = $urandom;
        o.sa    = 5'($urandom);
        o.right = 1'($urandom);
        o.arith = 1'($urandom);
        if ($urandom_range(0, 5) == 0) o.sa = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
        return o;
    endfunction

    // Returns {carry, sh}; carry is the last bit pushed out of the word.
    function automatic logic [32:0] ref_shift(input op_t o);
        logic [32:0] u;
        if (!o.right) begin
            u = {1'b0, o.d} << o.sa;
            return u;
        end
        u = {o.d, 1'b0};
        if (o.arith) u = $signed(u) >>> o.sa;
        else         u = u >> o.sa;
        return {u[0], u[32:1]};
    endfunction

    function automatic bit ref_pick(input bit r0, input bit r1, input bit fair, input bit last);
        if (r0 && r1) return fair ? !last : 1'b0;
        return r1;
    endfunction

    // Entered at posedge+1 with both DUTs idle; leaves at posedge+1 after the accept edge.
    task automatic run_op(input bit r0, input bit r1, input op_t o0, input op_t o1,
                          input bit h0, input bit h1, input int stall,
                          output logic [31:0] got_sh, output logic got_id, output logic got_fid);
        bit wf, wp;
        logic [32:0] ef, ep;
        req0 = r0; d0 = o0.d; sa0 = o0.sa; right0 = o0.right; arith0 = o0.arith;
        req1 = r1; d1 = o1.d; sa1 = o1.sa; right1 = o1.right; arith1 = o1.arith;
        resp_ready = (stall == 0);
        wf = ref_pick(r0, r1, 1'b1, m_last);
        wp = ref_pick(r0, r1, 1'b0, 1'b0);
        ef = wf ? ref_shift(o1) : ref_shift(o0);
        ep = wp ? ref_shift(o1) : ref_shift(o0);
        m_last = wf;
        got_sh = 'x; got_id = 1'bx; got_fid = 1'bx;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== {!wf, wf}) begin
            errors++;
            $display("FAIL grant: gnt0=%b gnt1=%b expected %b%b", gnt0, gnt1, !wf, wf);
        end
        checks++;
        if ({f_gnt0, f_gnt1} !== {!wp, wp}) begin
            errors++;
            $display("FAIL fp_grant: gnt0=%b gnt1=%b expected %b%b", f_gnt0, f_gnt1, !wp, wp);
        end
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle: busy=%b resp_valid=%b expected 0 0", busy, resp_valid);
        end
        @(posedge clk); #1;
        req0 = h0; req1 = h1;
        d0 = $urandom; d1 = $urandom; sa0 = 5'($urandom); sa1 = 5'($urandom);
        right0 = 1'($urandom); right1 = 1'($urandom); arith0 = 1'($urandom); arith1 = 1'($urandom);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL exec: busy=%b resp_valid=%b gnt=%b%b expected 1 0 00", busy, resp_valid, gnt0, gnt1);
        end
        @(posedge clk); #1;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(posedge clk); #1;
                resp_ready = (s == stall);
            end
            @(negedge clk);
            if (s == 0) begin
                got_sh = sh; got_id = resp_id; got_fid = f_resp_id;
            end
            checks++;
            if (resp_valid !== 1'b1 || busy !== 1'b1 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL resp_hold: resp_valid=%b busy=%b gnt=%b%b expected 1 1 00", resp_valid, busy, gnt0, gnt1);
            end
            checks++;
            if ({carry, sh} !== ef || resp_id !== wf) begin
                errors++;
                $display("FAIL resp_data: carry=%b sh=%h id=%b expected %b %h %b", carry, sh, resp_id, ef[32], ef[31:0], wf);
            end
            checks++;
            if ({f_carry, f_sh} !== ep || f_resp_id !== wp || f_resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL fp_resp: carry=%b sh=%h id=%b valid=%b expected %b %h %b 1", f_carry, f_sh, f_resp_id, f_resp_valid, ep[32], ep[31:0], wp);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || f_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: resp_valid=%b busy=%b fp_valid=%b expected 0 0 0", resp_valid, busy, f_resp_valid);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; req0 = 0; req1 = 0; resp_ready = 0;
        d0 = '0; d1 = '0; sa0 = '0; sa1 = '0; right0 = 0; right1 = 0; arith0 = 0; arith1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        m_last = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || sh !== 32'h0 || carry !== 1'b0 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: valid=%b busy=%b sh=%h carry=%b id=%b expected 0 0 0 0 0", resp_valid, busy, sh, carry, resp_id);
        end
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: gnt=%b%b expected 00", gnt0, gnt1);
        end
    endtask

    task automatic test_single_r0();
        logic [31:0] s; logic id, fid;
        run_op(1, 0, mk(32'hff0000ff, 5'd8, 0, 0), rand_op(), 0, 0, 0, s, id, fid);
        checks++;
        if (s !== 32'h0000ff00 || id !== 1'b0) begin
            errors++;
            $display("FAIL single_r0: sh=%h id=%b expected 0000ff00 0", s, id);
        end
    endtask

    task automatic test_shifts();
        logic [31:0] s; logic id, fid;
        run_op(0, 1, rand_op(), mk(32'h80000000, 5'd4, 1, 1), 0, 0, 0, s, id, fid);
        checks++;
        if (s !== 32'hf8000000 || id !== 1'b1) begin
            errors++;
            $display("FAIL arith_right: sh=%h id=%b expected f8000000 1", s, id);
        end
        run_op(0, 1, rand_op(), mk(32'h00000009, 5'd8, 1, 0), 0, 0, 0, s, id, fid);
        checks++;
        if (s !== 32'h00000000) begin
            errors++;
            $display("FAIL logic_right: sh=%h expected 00000000", s);
        end
        run_op(1, 0, mk(32'h12345678, 5'd0, 1, 1), rand_op(), 0, 0, 0, s, id, fid);
        checks++;
        if (s !== 32'h12345678) begin
            errors++;
            $display("FAIL sa_zero: sh=%h expected 12345678", s);
        end
        run_op(0, 1, rand_op(), mk(32'h80000001, 5'd1, 0, 1), 0, 0, 0, s, id, fid);
        checks++;
        if (s !== 32'h00000002) begin
            errors++;
            $display("FAIL left_arith_ignored: sh=%h expected 00000002", s);
        end
        run_op(0, 1, rand_op(), mk(32'h80000000, 5'd31, 1, 1), 0, 0, 0, s, id, fid);
        checks++;
        if (s !== 32'hffffffff) begin
            errors++;
            $display("FAIL arith_sa31: sh=%h expected ffffffff", s);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] s; logic id, fid;
        for (int k = 0; k < 4; k++) begin
            run_op(1, 1, rand_op(), rand_op(), k < 3, k < 3, 0, s, id, fid);
            checks++;
            if (id !== 1'(k % 2) || fid !== 1'b0) begin
                errors++;
                $display("FAIL rr_order[%0d]: fair_id=%b fixed_id=%b expected %0d 0", k, id, fid, k % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s; logic id, fid;
        run_op(1, 0, rand_op(), rand_op(), 0, 1, 5, s, id, fid);
        run_op(0, 1, rand_op(), rand_op(), 0, 0, 0, s, id, fid);
        checks++;
        if (id !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_grant: id=%b expected 1", id);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s; logic id, fid;
        req0 = 1; req1 = 0; d0 = 32'h0000ffff; sa0 = 5'd4; right0 = 0; arith0 = 0;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant: gnt0=%b expected 1", gnt0);
        end
        @(posedge clk); #1;
        req0 = 0;
        clrn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || sh !== 32'h0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b valid=%b sh=%h expected 0 0 0", busy, resp_valid, sh);
        end
        @(negedge clk);
        clrn = 1'b1;
        m_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_resp[%0d]: valid=%b busy=%b expected 0 0", i, resp_valid, busy);
            end
        end
        run_op(1, 1, rand_op(), rand_op(), 0, 0, 0, s, id, fid);
        checks++;
        if (id !== 1'b0) begin
            errors++;
            $display("FAIL abort_last_id: id=%b expected 0", id);
        end
    endtask

    task automatic test_random();
        logic [31:0] s; logic id, fid;
        int r;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(1, 3);
            run_op(r[0], r[1], rand_op(), rand_op(), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), s, id, fid);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_r0();
        test_shifts();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one 32-bit barrel shifter instance (shift_mux) between two requesters, e.g. the ALU shift path and the address-generation unit. Each requester gets a one-cycle grant handshake. Granted operands are captured, the shift is evaluated and registered, and the result is returned with a requester ID under a valid/ready response handshake. The arbitration is round-robin and the controller runs one operation at a time.

Parameters:
FAIR, 1, 1 = round-robin between r0/r1; 0 = fixed priority, r0 always wins a tie.

Ports:
clk  input  1  clock, all state updates on the rising edge
clrn  input  1  asynchronous active-low reset
req0  input  1  requester 0 request; held with its operands until gnt0 is seen
d0  input  32  requester 0 shift data
sa0  input  5  requester 0 shift amount
right0  input  1  requester 0 direction, 1 = right
arith0  input  1  requester 0 arithmetic right shift
gnt0  output  1  requester 0 grant, combinational, one cycle
req1, d1, sa1, right1, arith1, gnt1  as for requester 0
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts the result
resp_id  output  1  ID of the requester that owns the result
sh  output  32  registered shift result
carry  output  1  registered carry from shift_mux
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (clrn=0, asynchronous) forces the following:
  - state=IDLE, resp_valid=0, resp_id=0, sh=0, carry=0, busy=0;
  - captured operands cleared;
  - last_id=1, so r0 wins the first tie.
- Reset mid-operation discards the in-flight operation; no response is produced for it.
- State machine IDLE -> EXEC -> RESP -> IDLE:
  - IDLE: if req0|req1, assert exactly one grant combinationally. At the clock edge, capture that requester's d/sa/right/arith and its ID into operand registers, update last_id, and go to EXEC. With no request, stay in IDLE.
  - EXEC: the internal shift_mux is driven from the operand registers. At the edge, register its sh/carry outputs, set resp_valid=1, and go to RESP.
  - RESP: hold sh, carry, resp_id and resp_valid=1 stable. On resp_valid&resp_ready at the edge, clear resp_valid and go to IDLE. Otherwise stay in RESP with no timeout.
- Grant rules:
  - gnt0/gnt1 are only asserted in IDLE and are never asserted together.
  - Tie with FAIR=1: grant the requester whose ID is not equal to last_id.
  - Tie with FAIR=0: grant r0.
  - A single requester is always granted.
- Latency: request granted in cycle T; resp_valid rises at the start of T+2. Minimum issue interval is 3 cycles per operation.
- A request arriving while busy=1 gets no grant and waits; requests are not queued internally.
- Requester obligation: deassert req (or present a new operation) after the cycle in which gnt was high. A req held high after its grant is treated as a new request once the controller returns to IDLE.
- Shift semantics are exactly those of shift_mux:
  - left shift fills zeros;
  - logical right shift fills zeros;
  - arithmetic right shift (right=1, arith=1) replicates d[31];
  - arith is ignored when right=0;
  - sa=0 passes d unchanged.
- The operand register isolates the shifter from requester input changes after the grant.
- resp_ready asserted in IDLE or EXEC has no effect.

Test Plan:
- Reset: assert clrn=0 for 2 cycles, then release -> resp_valid=0, busy=0, sh=0, gnt0=gnt1=0.
- Single r0 request: req0=1, d0=ff0000ff, sa0=8, right0=0 -> gnt0 high in the request cycle; resp_valid high 2 cycles later with sh=0000ff00, resp_id=0.
- Arithmetic and logical right shifts via r1:
  - d1=80000000, sa1=4, right1=1, arith1=1 -> sh=f8000000, resp_id=1.
  - d1=00000009, sa1=8, right1=1, arith1=0 -> sh=00000000.
- Round-robin tie (FAIR=1): req0 and req1 held high for 4 operations with resp_ready=1 -> grant order r0, r1, r0, r1; responses carry matching resp_id and the correct sh. With FAIR=0 the same stimulus grants r0 every time.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid rises while req1=1 -> sh/resp_id stay stable, gnt1 stays 0, busy=1. Raise resp_ready -> resp_valid falls, and gnt1 asserts in the next cycle.
- Reset mid-operation: pulse clrn low during EXEC -> no response is produced, state is IDLE, and a tied request afterwards grants r0 (last_id reset to 1).
